// File: rtl/vga_config_loader.sv
// SPI byte-stream to pixel-mux configuration loader; commits staged words at frame start.
// Optional readback path guarded by macro VGA_CFG_READBACK_EN.
module vga_config_loader #(
    parameter logic [31:0] RESET_CONFIG = 32'h80FC_0000,
    parameter logic [7:0]  CMD_WRITE    = 8'hA5,
    parameter logic [7:0]  CMD_READ     = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ss,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        frame_start,
    output logic [31:0] config_out,
    output logic [7:0]  tx_data,
    output logic        update_pending,
    output logic        cmd_error
);

    localparam int unsigned CFG_W = 32;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
`ifdef VGA_CFG_READBACK_EN
        S_RDATA,
`endif
        S_DROP
    } state_e;

    state_e             state_q;
    logic [CFG_W-1:0]   shift_q;
    logic [CFG_W-1:0]   staged_q;
    logic [CFG_W-1:0]   config_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pending_q;
    logic               err_q;

    logic               wr_done_c;
    logic               is_read_c;
    logic [CFG_W-1:0]   shift_d;

    assign shift_d   = {shift_q[23:0], rx_data};
    assign is_read_c = (rx_data == CMD_READ);
    // A write finishing this cycle blocks the commit so a stale staged word is never applied
    assign wr_done_c = !ss && (state_q == S_WDATA) && rx_valid && (cnt_q == CNT_W'(3));

`ifdef VGA_CFG_READBACK_EN
    logic [7:0] tx_q;
    assign tx_data = tx_q;
`else
    assign tx_data = 8'h00;
`endif

    assign config_out     = config_q;
    assign update_pending = pending_q;
    assign cmd_error      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            staged_q  <= RESET_CONFIG;
            config_q  <= RESET_CONFIG;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef VGA_CFG_READBACK_EN
            tx_q      <= 8'h00;
`endif
        end else begin
            err_q <= 1'b0;

            if (frame_start && pending_q && !wr_done_c) begin
                config_q  <= staged_q;
                pending_q <= 1'b0;
            end

            if (ss) begin
                state_q <= S_IDLE;
                shift_q <= '0;
                cnt_q   <= '0;
`ifdef VGA_CFG_READBACK_EN
                tx_q    <= 8'h00;
`endif
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_CMD;

                    S_CMD: begin
                        if (rx_valid) begin
                            cnt_q <= '0;
                            if (rx_data == CMD_WRITE) begin
                                state_q <= S_WDATA;
`ifdef VGA_CFG_READBACK_EN
                            end else if (is_read_c) begin
                                state_q <= S_RDATA;
                                tx_q    <= config_q[31:24];
`else
                            end else if (is_read_c) begin
                                // Readback not built: read command is rejected like any unknown byte
                                state_q <= S_DROP;
                                err_q   <= 1'b1;
`endif
                            end else begin
                                state_q <= S_DROP;
                                err_q   <= 1'b1;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (rx_valid) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(3)) begin
                                staged_q  <= shift_d;
                                pending_q <= 1'b1;
                                state_q   <= S_DROP;
                            end
                        end
                    end

`ifdef VGA_CFG_READBACK_EN
                    S_RDATA: begin
                        if (rx_valid) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            case (cnt_q)
                                2'd0:    tx_q <= config_q[23:16];
                                2'd1:    tx_q <= config_q[15:8];
                                2'd2:    tx_q <= config_q[7:0];
                                default: begin
                                    tx_q    <= 8'h00;
                                    state_q <= S_DROP;
                                end
                            endcase
                        end
                    end
`endif

                    S_DROP: state_q <= S_DROP;

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_config_loader.sv
// Directed self-checking bench for vga_config_loader (default and readback builds).
module tb_vga_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_start;
    logic [31:0] config_out;
    logic [7:0]  tx_data;
    logic        update_pending;
    logic        cmd_error;

    int checks = 0;
    int errors = 0;

    vga_config_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ss             (ss),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .frame_start    (frame_start),
        .config_out     (config_out),
        .tx_data        (tx_data),
        .update_pending (update_pending),
        .cmd_error      (cmd_error)
    );

    always #5 clk = ~clk;

    // Stimulus helpers are entered and left at a falling edge
    task automatic start_txn();
        ss = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_txn();
        ss = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        start_txn();
        send(8'hA5);
        send(t[31:24]);
        send(t[23:16]);
        send(t[15:8]);
        send(t[7:0]);
        end_txn();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (config_out !== 32'h80FC0000) begin
            errors++; $display("FAIL reset_config got %h exp %h", config_out, 32'h80FC0000);
        end
        checks++;
        if (update_pending !== 1'b0 || tx_data !== 8'h00 || cmd_error !== 1'b0) begin
            errors++; $display("FAIL reset_flags got pend=%b tx=%h err=%b exp 0 00 0",
                               update_pending, tx_data, cmd_error);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_commit();
        start_txn();
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        checks++;
        if (update_pending !== 1'b1) begin
            errors++; $display("FAIL wc_pending got %b exp 1", update_pending);
        end
        checks++;
        if (config_out !== 32'h80FC0000) begin
            errors++; $display("FAIL wc_no_early got %h exp %h", config_out, 32'h80FC0000);
        end
        end_txn();
        pulse_frame();
        checks++;
        if (config_out !== 32'h12345678) begin
            errors++; $display("FAIL wc_commit got %h exp %h", config_out, 32'h12345678);
        end
        checks++;
        if (update_pending !== 1'b0) begin
            errors++; $display("FAIL wc_pend_clr got %b exp 0", update_pending);
        end
    endtask

    task automatic test_readback();
        start_txn();
        send(8'h5A);
`ifdef VGA_CFG_READBACK_EN
        checks++;
        if (tx_data !== 8'h12) begin
            errors++; $display("FAIL rb_b0 got %h exp 12", tx_data);
        end
        send(8'hFF);
        checks++;
        if (tx_data !== 8'h34) begin
            errors++; $display("FAIL rb_b1 got %h exp 34", tx_data);
        end
        send(8'hFF);
        checks++;
        if (tx_data !== 8'h56) begin
            errors++; $display("FAIL rb_b2 got %h exp 56", tx_data);
        end
        send(8'hFF);
        checks++;
        if (tx_data !== 8'h78) begin
            errors++; $display("FAIL rb_b3 got %h exp 78", tx_data);
        end
        send(8'hFF);
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL rb_end got %h exp 00", tx_data);
        end
`else
        checks++;
        if (cmd_error !== 1'b1) begin
            errors++; $display("FAIL rb_off_err got %b exp 1", cmd_error);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL rb_off_tx got %h exp 00", tx_data);
        end
`endif
        end_txn();
        checks++;
        if (config_out !== 32'h12345678 || update_pending !== 1'b0) begin
            errors++; $display("FAIL rb_side got %h/%b exp 12345678/0", config_out, update_pending);
        end
    endtask

    task automatic test_abort();
        start_txn();
        send(8'hA5); send(8'hAA); send(8'hBB);
        end_txn();
        pulse_frame();
        checks++;
        if (config_out !== 32'h12345678 || update_pending !== 1'b0) begin
            errors++; $display("FAIL abort got %h/%b exp 12345678/0", config_out, update_pending);
        end
        write_word(32'h01020304);
        pulse_frame();
        checks++;
        if (config_out !== 32'h01020304) begin
            errors++; $display("FAIL abort_rewrite got %h exp %h", config_out, 32'h01020304);
        end
    endtask

    task automatic test_bad_cmd();
        start_txn();
        send(8'h3C);
        checks++;
        if (cmd_error !== 1'b1) begin
            errors++; $display("FAIL bad_err_hi got %b exp 1", cmd_error);
        end
        send(8'h11);
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++; $display("FAIL bad_err_lo got %b exp 0", cmd_error);
        end
        send(8'h22); send(8'h33); send(8'h44);
        end_txn();
        checks++;
        if (update_pending !== 1'b0 || config_out !== 32'h01020304) begin
            errors++; $display("FAIL bad_nopend got %h/%b exp 01020304/0", config_out, update_pending);
        end
    endtask

    task automatic test_last_write_wins();
        write_word(32'hCAFEBABE);
        write_word(32'hDEADBEEF);
        checks++;
        if (update_pending !== 1'b1 || config_out !== 32'h01020304) begin
            errors++; $display("FAIL lww_pre got %h/%b exp 01020304/1", config_out, update_pending);
        end
        pulse_frame();
        checks++;
        if (config_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lww got %h exp %h", config_out, 32'hDEADBEEF);
        end
        pulse_frame();
        checks++;
        if (config_out !== 32'hDEADBEEF || update_pending !== 1'b0) begin
            errors++; $display("FAIL idle_frame got %h/%b exp DEADBEEF/0", config_out, update_pending);
        end
    endtask

    task automatic test_collision();
        // Leave a stale word pending so a wrongly allowed commit would be visible
        write_word(32'h55556666);
        start_txn();
        send(8'hA5); send(8'hA1); send(8'hB2); send(8'hC3);
        frame_start = 1'b1;
        send(8'hD4);
        frame_start = 1'b0;
        checks++;
        if (config_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL coll_nocommit got %h exp %h", config_out, 32'hDEADBEEF);
        end
        checks++;
        if (update_pending !== 1'b1) begin
            errors++; $display("FAIL coll_pending got %b exp 1", update_pending);
        end
        end_txn();
        pulse_frame();
        checks++;
        if (config_out !== 32'hA1B2C3D4 || update_pending !== 1'b0) begin
            errors++; $display("FAIL coll_commit got %h/%b exp A1B2C3D4/0", config_out, update_pending);
        end
    endtask

    task automatic test_async_reset();
        write_word(32'h0BADF00D);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (config_out !== 32'h80FC0000 || update_pending !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL async_reset got %h/%b/%h exp 80FC0000/0/00",
                               config_out, update_pending, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_frame();
        checks++;
        if (config_out !== 32'h80FC0000) begin
            errors++; $display("FAIL async_staged got %h exp %h", config_out, 32'h80FC0000);
        end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_readback();
        test_abort();
        test_bad_cmd();
        test_last_write_wins();
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
